// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: carries PC, instruction, hazard timing and
// register specifiers between stages, with stall/flush handling and a bubble counter.
module pipe_stage_reg #(
   parameter int              PC_W          = 32,
   parameter int              INS_W         = 32,
   parameter int              T_W           = 2,
   parameter int              REG_W         = 5,
   parameter logic [PC_W-1:0] PC_RESET      = PC_W'(32'h0000_3000),
   parameter bit              DEC_TNEW      = 1'b1,
   parameter bit              FLUSH_KEEP_PC = 1'b0,
   parameter int              CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [PC_W-1:0]  pc,
   input  logic [INS_W-1:0] ins,
   input  logic [T_W-1:0]   Tuse,
   input  logic [T_W-1:0]   Tnew,
   input  logic [REG_W-1:0] rs,
   input  logic [REG_W-1:0] rt,
   input  logic [REG_W-1:0] rd,
   output logic [PC_W-1:0]  pc_o,
   output logic [INS_W-1:0] ins_o,
   output logic [T_W-1:0]   Tuse_o,
   output logic [T_W-1:0]   Tnew_o,
   output logic [REG_W-1:0] rs_o,
   output logic [REG_W-1:0] rt_o,
   output logic [REG_W-1:0] rd_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] bubble_cnt
);

   function automatic logic [T_W-1:0] tnew_dec_sat(input logic [T_W-1:0] t);
      return (t == '0) ? t : t - 1'b1;
   endfunction

   function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   logic [PC_W-1:0]  pc_p1;
   logic [INS_W-1:0] ins_p1;
   logic [T_W-1:0]   tuse_p1;
   logic [T_W-1:0]   tnew_p1;
   logic [REG_W-1:0] rs_p1;
   logic [REG_W-1:0] rt_p1;
   logic [REG_W-1:0] rd_p1;
   logic             vld_p1;
   logic [CNT_W-1:0] bubble_cnt_p1;

   logic             do_bubble;
   logic             do_load;
   logic [T_W-1:0]   tnew_next;
   logic [PC_W-1:0]  pc_bubble;

   // flush outranks stall; an idle (invalid) slot only becomes a bubble when not stalled
   assign do_bubble = flush | (~stall & ~in_valid);
   assign do_load   = ~flush & ~stall & in_valid;
   assign tnew_next = DEC_TNEW ? tnew_dec_sat(Tnew) : Tnew;
   assign pc_bubble = FLUSH_KEEP_PC ? pc : PC_RESET;

   // ---- stage register (input -> p1) ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_p1         <= PC_RESET;
         ins_p1        <= '0;
         tuse_p1       <= '0;
         tnew_p1       <= '0;
         rs_p1         <= '0;
         rt_p1         <= '0;
         rd_p1         <= '0;
         vld_p1        <= 1'b0;
         bubble_cnt_p1 <= '0;
      end else if (do_bubble) begin
         pc_p1         <= pc_bubble;
         ins_p1        <= '0;
         tuse_p1       <= '0;
         tnew_p1       <= '0;
         rs_p1         <= '0;
         rt_p1         <= '0;
         rd_p1         <= '0;
         vld_p1        <= 1'b0;
         bubble_cnt_p1 <= cnt_inc_sat(bubble_cnt_p1);
      end else if (do_load) begin
         pc_p1         <= pc;
         ins_p1        <= ins;
         tuse_p1       <= Tuse;
         tnew_p1       <= tnew_next;
         rs_p1         <= rs;
         rt_p1         <= rt;
         rd_p1         <= rd;
         vld_p1        <= 1'b1;
      end
   end

   assign pc_o       = pc_p1;
   assign ins_o      = ins_p1;
   assign Tuse_o     = tuse_p1;
   assign Tnew_o     = tnew_p1;
   assign rs_o       = rs_p1;
   assign rt_o       = rt_p1;
   assign rd_o       = rd_p1;
   assign valid_o    = vld_p1;
   assign bubble_cnt = bubble_cnt_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: two instances (decrementing / keep-PC with a
// 3-bit counter) share stimulus; hand-computed expectations are queued per edge.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, in_valid;
   logic [31:0] pc, ins;
   logic [1:0]  Tuse, Tnew;
   logic [4:0]  rs, rt, rd;

   logic [31:0] pc_a, ins_a, pc_b, ins_b;
   logic [1:0]  tuse_a, tnew_a, tuse_b, tnew_b;
   logic [4:0]  rs_a, rt_a, rd_a, rs_b, rt_b, rd_b;
   logic        valid_a, valid_b;
   logic [15:0] cnt_a;
   logic [2:0]  cnt_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] pc_a, pc_b, ins;
      logic [1:0]  tuse, tnew_a, tnew_b;
      logic [4:0]  rs, rt, rd;
      logic        valid;
      logic [15:0] cnt_a;
      logic [2:0]  cnt_b;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   pipe_stage_reg #(.DEC_TNEW(1'b1), .FLUSH_KEEP_PC(1'b0), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
      .pc(pc), .ins(ins), .Tuse(Tuse), .Tnew(Tnew), .rs(rs), .rt(rt), .rd(rd),
      .pc_o(pc_a), .ins_o(ins_a), .Tuse_o(tuse_a), .Tnew_o(tnew_a),
      .rs_o(rs_a), .rt_o(rt_a), .rd_o(rd_a), .valid_o(valid_a), .bubble_cnt(cnt_a));

   pipe_stage_reg #(.DEC_TNEW(1'b0), .FLUSH_KEEP_PC(1'b1), .CNT_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
      .pc(pc), .ins(ins), .Tuse(Tuse), .Tnew(Tnew), .rs(rs), .rt(rt), .rd(rd),
      .pc_o(pc_b), .ins_o(ins_b), .Tuse_o(tuse_b), .Tnew_o(tnew_b),
      .rs_o(rs_b), .rt_o(rt_b), .rd_o(rd_b), .valid_o(valid_b), .bubble_cnt(cnt_b));

   function automatic exp_t mk(input string n, input logic [31:0] pa, pb, i,
                               input logic [1:0] tu, tna, tnb, input logic [4:0] a, b, c,
                               input logic v, input logic [15:0] ca, input logic [2:0] cb);
      exp_t e;
      e.name = n; e.pc_a = pa; e.pc_b = pb; e.ins = i; e.tuse = tu;
      e.tnew_a = tna; e.tnew_b = tnb; e.rs = a; e.rt = b; e.rd = c;
      e.valid = v; e.cnt_a = ca; e.cnt_b = cb;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Monitor: one expectation per clock (or per asynchronous reset), sampled 1 ns later
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, ".a.pc"},    pc_a,    e.pc_a);
            chk({e.name, ".b.pc"},    pc_b,    e.pc_b);
            chk({e.name, ".a.ins"},   ins_a,   e.ins);
            chk({e.name, ".b.ins"},   ins_b,   e.ins);
            chk({e.name, ".a.tuse"},  32'(tuse_a), 32'(e.tuse));
            chk({e.name, ".b.tuse"},  32'(tuse_b), 32'(e.tuse));
            chk({e.name, ".a.tnew"},  32'(tnew_a), 32'(e.tnew_a));
            chk({e.name, ".b.tnew"},  32'(tnew_b), 32'(e.tnew_b));
            chk({e.name, ".a.regs"},  32'({rs_a, rt_a, rd_a}), 32'({e.rs, e.rt, e.rd}));
            chk({e.name, ".b.regs"},  32'({rs_b, rt_b, rd_b}), 32'({e.rs, e.rt, e.rd}));
            chk({e.name, ".a.valid"}, 32'(valid_a), 32'(e.valid));
            chk({e.name, ".b.valid"}, 32'(valid_b), 32'(e.valid));
            chk({e.name, ".a.cnt"},   32'(cnt_a), 32'(e.cnt_a));
            chk({e.name, ".b.cnt"},   32'(cnt_b), 32'(e.cnt_b));
         end
      end
   end

   task automatic step(input logic f, s, v, input logic [31:0] p, i,
                       input logic [1:0] tu, tn, input logic [4:0] a, b, c, input exp_t e);
      @(negedge clk);
      #2;
      flush = f; stall = s; in_valid = v; pc = p; ins = i;
      Tuse = tu; Tnew = tn; rs = a; rt = b; rd = c;
      q.push_back(e);
      @(posedge clk);
   endtask

   initial begin
      // stall=1 keeps the edges around reset release as holds
      rst_n = 1'b0; stall = 1'b1; flush = 1'b0; in_valid = 1'b0;
      pc = '0; ins = '0; Tuse = '0; Tnew = '0; rs = '0; rt = '0; rd = '0;
      q.push_back(mk("rst0", 32'h3000, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      #3 rst_n = 1'b1;

      step(0, 0, 1, 32'h4000, 32'h1234_5678, 1, 3, 1, 2, 3,
           mk("pre_rst", 32'h4000, 32'h4000, 32'h1234_5678, 1, 2, 3, 1, 2, 3, 1, 0, 0));

      // asynchronous reset in the middle of a cycle, checked before the next edge
      @(negedge clk);
      #2 stall = 1'b1;
      q.push_back(mk("async_rst", 32'h3000, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b0;
      @(negedge clk);
      #3 rst_n = 1'b1;

      step(0, 0, 1, 32'h3004, 32'h0109_4020, 1, 2, 8, 9, 8,
           mk("load_tn2", 32'h3004, 32'h3004, 32'h0109_4020, 1, 1, 2, 8, 9, 8, 1, 0, 0));
      step(0, 0, 1, 32'h3004, 32'h0109_4020, 1, 0, 8, 9, 8,
           mk("load_tn0", 32'h3004, 32'h3004, 32'h0109_4020, 1, 0, 0, 8, 9, 8, 1, 0, 0));
      step(0, 0, 1, 32'h3008, 32'h8C01_0004, 2, 3, 1, 2, 3,
           mk("load_3008", 32'h3008, 32'h3008, 32'h8C01_0004, 2, 2, 3, 1, 2, 3, 1, 0, 0));
      for (int k = 0; k < 3; k++)
         step(0, 1, 1, 32'h300C, 32'hAC22_0008, 0, 1, 4, 5, 6,
              mk("stall", 32'h3008, 32'h3008, 32'h8C01_0004, 2, 2, 3, 1, 2, 3, 1, 0, 0));
      step(0, 0, 1, 32'h300C, 32'hAC22_0008, 0, 1, 4, 5, 6,
           mk("stall_rel", 32'h300C, 32'h300C, 32'hAC22_0008, 0, 0, 1, 4, 5, 6, 1, 0, 0));
      step(1, 1, 1, 32'h3010, 32'hAC22_0008, 0, 1, 4, 5, 6,
           mk("flush_stall", 32'h3000, 32'h3010, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      step(0, 0, 0, 32'h3014, 32'hFFFF_FFFF, 3, 3, 7, 7, 7,
           mk("invalid", 32'h3000, 32'h3014, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2));
      step(0, 1, 0, 32'h3014, 32'hFFFF_FFFF, 3, 3, 7, 7, 7,
           mk("stall_inv", 32'h3000, 32'h3014, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2));
      // nine flushes: the 3-bit counter climbs 3..7 and then sticks at 7
      for (int k = 1; k <= 9; k++)
         step(1, 0, 1, 32'h3018, 32'h1111_2222, 1, 1, 1, 1, 1,
              mk("sat", 32'h3000, 32'h3018, 0, 0, 0, 0, 0, 0, 0, 0,
                 16'(2 + k), (k >= 5) ? 3'd7 : 3'(2 + k)));
      step(0, 0, 1, 32'h301C, 32'h0000_0001, 3, 1, 31, 0, 31,
           mk("load_post", 32'h301C, 32'h301C, 32'h0000_0001, 3, 0, 1, 31, 0, 31, 1, 11, 7));

      repeat (2) @(negedge clk);
      #3;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0 pending expectations", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
